// File: rtl/lfsr_if.sv
// Coordinate bus carrying the two random 4-bit grid fields from the LFSR
// to the game logic that consumes them.
interface lfsr_if;
   logic [3:0] x;
   logic [3:0] y;

   modport master (output x, output y);
   modport slave  (input  x, input  y);
endinterface

// File: rtl/lfsr.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) that supplies
// random tile coordinates; x and y are direct slices of the state register.
module lfsr #(
   parameter int              WIDTH = 16,
   parameter logic [WIDTH-1:0] SEED = 16'hACE1
) (
   input  logic  clk,
   input  logic  reset,
   lfsr_if.master bus
);

   logic [WIDTH-1:0] state;
   logic             fb;

   assign fb = state[0] ^ state[2] ^ state[3] ^ state[5];

   // An all-zero state can only appear through an upset; reload SEED to escape it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SEED;
      end else if (state == '0) begin
         state <= SEED;
      end else begin
         state <= {fb, state[WIDTH-1:1]};
      end
   end

   assign bus.x = state[3:0];
   assign bus.y = state[11:8];

endmodule

// File: tb/tb_lfsr.sv
// Directed bench for lfsr: reset behaviour, first steps, async mid-run reset,
// lock-up recovery and a full-period sweep with x/y histograms.
module tb_lfsr;

   localparam logic [15:0] SEED = 16'hACE1;

   logic   clk;
   logic   reset;
   lfsr_if bus ();

   int total;
   int bad;

   lfsr #(.WIDTH(16), .SEED(SEED)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference step written straight from the polynomial, with lock-up reload.
   function automatic logic [15:0] model_step(input logic [15:0] s);
      logic f;
      if (s == 16'h0000) return SEED;
      f = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {f, s[15:1]};
   endfunction

   task automatic check_xy(input string name, input logic [3:0] ex, input logic [3:0] ey);
      total++;
      if (bus.x !== ex || bus.y !== ey) begin
         bad++;
         $display("[TB] FAIL %s: x=%h y=%h, required x=%h y=%h", name, bus.x, bus.y, ex, ey);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      check_xy("reset_no_edge", 4'h1, 4'hC);
      repeat (3) @(negedge clk);
      check_xy("reset_held", 4'h1, 4'hC);
   endtask

   // Releases reset on a falling edge and checks the first three hand-computed states.
   task automatic test_first_steps(input string tag);
      logic [3:0] ex [4];
      logic [3:0] ey [4];
      ex = '{4'h1, 4'h0, 4'h8, 4'hC};
      ey = '{4'hC, 4'h6, 4'hB, 4'h5};
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_xy({tag, "_step0"}, ex[0], ey[0]);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         check_xy($sformatf("%s_step%0d", tag, i), ex[i], ey[i]);
      end
      total++;
      if (dut.state !== 16'h559C) begin
         bad++;
         $display("[TB] FAIL %s_state3: state=%h, required 559c", tag, dut.state);
      end
   endtask

   task automatic test_mid_reset();
      repeat (7) @(negedge clk);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_xy("mid_reset_async", 4'h1, 4'hC);
      total++;
      if (dut.state !== SEED) begin
         bad++;
         $display("[TB] FAIL mid_reset_state: state=%h, required %h", dut.state, SEED);
      end
      @(negedge clk);
      check_xy("mid_reset_held", 4'h1, 4'hC);
      test_first_steps("after_mid_reset");
   endtask

   task automatic test_lockup();
      @(negedge clk);
      force dut.state = 16'h0000;
      #1;
      release dut.state;
      #1;
      check_xy("lockup_zero", 4'h0, 4'h0);
      @(negedge clk);
      check_xy("lockup_recover", 4'h1, 4'hC);
      total++;
      if (dut.state !== SEED) begin
         bad++;
         $display("[TB] FAIL lockup_state: state=%h, required %h", dut.state, SEED);
      end
   endtask

   task automatic test_full_period();
      int          hx [16];
      int          hy [16];
      int          seq_err;
      int          zero_seen;
      logic [15:0] exp_s;
      for (int i = 0; i < 16; i++) begin
         hx[i] = 0;
         hy[i] = 0;
      end
      seq_err   = 0;
      zero_seen = 0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      exp_s = SEED;
      for (int i = 0; i < 65535; i++) begin
         if (bus.x !== exp_s[3:0] || bus.y !== exp_s[11:8]) begin
            if (seq_err == 0)
               $display("[TB] FAIL period_seq at step %0d: x=%h y=%h, required x=%h y=%h",
                        i, bus.x, bus.y, exp_s[3:0], exp_s[11:8]);
            seq_err++;
         end
         if (dut.state === 16'h0000) zero_seen++;
         hx[bus.x]++;
         hy[bus.y]++;
         exp_s = model_step(exp_s);
         @(negedge clk);
      end
      total++;
      if (seq_err != 0) bad++;
      total++;
      if (zero_seen != 0) begin
         bad++;
         $display("[TB] FAIL period_zero: zero seen %0d times, required 0", zero_seen);
      end
      total++;
      if (dut.state !== SEED) begin
         bad++;
         $display("[TB] FAIL period_wrap: state=%h, required %h", dut.state, SEED);
      end
      for (int v = 0; v < 16; v++) begin
         int req;
         req = (v == 0) ? 4095 : 4096;
         total++;
         if (hx[v] != req) begin
            bad++;
            $display("[TB] FAIL hist_x[%0d]: count=%0d, required %0d", v, hx[v], req);
         end
         total++;
         if (hy[v] != req) begin
            bad++;
            $display("[TB] FAIL hist_y[%0d]: count=%0d, required %0d", v, hy[v], req);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_first_steps("release");
      test_mid_reset();
      test_lockup();
      test_full_period();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
